cnt_share_pipe_array: RTL
=========================

CNT_SHARE_PIPE_ARRAY -- requirements
Module: cnt_share_pipe_array

Interface
REQ-001 SHALL have parameter CWID, default 8, counter and sequence width.
REQ-002 SHALL have parameter BDIM, default 4, number of independent buffer groups.
REQ-003 SHALL have parameter SDIM, default 8, sharing fan-out per buffer group.
REQ-004 SHALL have parameter BLAT, default 1, buffer pipeline stages per group (legal range 1..8).
REQ-005 SHALL have one clock; reset is synchronous and active-high. Ports: clk  in  1  clock, rising edge.
REQ-006 SHALL have rst  in  1  synchronous active-high reset.
REQ-007 SHALL have enable  in  1  count advance qualifier.
REQ-008 SHALL have start  in  1  run request, IDLE only.
REQ-009 SHALL have stop  in  1  early run termination.
REQ-010 SHALL have clr  in  1  synchronous counter and period-count clear.
REQ-011 SHALL have period_max  in  CWID  terminal count, sampled on start.
REQ-012 SHALL have len  in  16  periods per run, sampled on start; 0 = free-run.
REQ-013 SHALL have busy  out  1  high in RUN and DRAIN.
REQ-014 SHALL have done  out  1  one-cycle run-complete pulse.
REQ-015 SHALL have cnt_seq  out  [BDIM*SDIM][CWID]  shared sequence; entry i*SDIM+j is driven by group i.
REQ-016 SHALL have seq_vld  out  BDIM  per-group valid, aligned with cnt_seq.
REQ-017 SHALL have seq_wrap  out  BDIM  per-group terminal-count flag, aligned with cnt_seq.

Function
REQ-018 FSM states SHALL be IDLE, RUN, DRAIN, DONE.
REQ-019 IDLE->RUN SHALL occur on start=1; start SHALL be ignored in every other state.
REQ-020 In RUN with enable=1, cnt SHALL advance by 1 per cycle, and cnt==period_q SHALL force cnt to 0 on the next cycle and raise internal wrap.
REQ-021 period_q=0 SHALL hold cnt at 0 and flag wrap on every enabled cycle.
REQ-022 With enable=0 in RUN, cnt and period count SHALL hold, and stage-0 valid SHALL be 0.
REQ-023 RUN->DRAIN SHALL occur on the cycle wrap coincides with period count == len_q-1 (len_q!=0), or on stop=1; stop SHALL take priority.
REQ-024 DRAIN SHALL last exactly BLAT cycles, then go to DONE; DONE SHALL assert done for one cycle, then go to IDLE.
REQ-025 Stage 0 of each group SHALL capture {cnt, RUN&enable, wrap}; stage BLAT-1 SHALL drive cnt_seq, seq_vld and seq_wrap.
REQ-026 Output latency from counter value to cnt_seq SHALL be exactly BLAT cycles.
REQ-027 clr SHALL zero cnt and period count in any state without changing FSM state; clr SHALL override counting in the same cycle.
REQ-028 start and clr in the same cycle SHALL enter RUN with cnt=0.
REQ-029 The period counter SHALL be 16 bits and SHALL wrap silently in free-run mode.

Reset
REQ-030 rst SHALL force IDLE and clear cnt, period count, period_q, len_q and all pipeline stages; all outputs SHALL read 0.
REQ-031 rst asserted mid-RUN SHALL abort without a done pulse.

Configuration
REQ-032 With CNT_SHARE_BITREV_EN defined, stage 0 SHALL capture cnt bit-reversed (van der Corput order); undefined, it SHALL capture binary cnt. Wrap, valid and FSM timing SHALL be identical in both builds.

Structure
REQ-033 Package cnt_share_pkg SHALL hold the FSM state enum, the period-counter width constant (16) and the BLAT legality bounds.
REQ-034 Sub-module cnt_wrap SHALL implement the enabled, clearable, terminal-count counter with wrap output.

Verification
REQ-035 Test: period_max=3, len=2, BLAT=1, enable=1, start pulse -> cnt_seq 0,1,2,3,0,1,2,3 starting 2 cycles after start; seq_wrap high on each 3; done 1 cycle after DRAIN.
REQ-036 Test: enable toggled 1,0,1 in RUN -> cnt holds through the gap; seq_vld=0 for the gap cycle only.
REQ-037 Test: len=0, period_max=7, stop after 20 cycles -> DRAIN BLAT cycles, done pulse, busy=0.
REQ-038 Test: rst at cnt=5 mid-RUN -> all outputs 0 next cycle, no done pulse.
REQ-039 Test: CNT_SHARE_BITREV_EN, CWID=3, period_max=7 -> cnt_seq 0,4,2,6,1,5,3,7.
REQ-040 Test: BLAT=3, SDIM=8 -> all 8 entries of each group equal, lagging the counter by exactly 3 cycles.

Source files
------------

// File: rtl/cnt_share_pkg.sv
// cnt_share_pkg: FSM states, period-counter width and BLAT bounds shared by the counter array.
package cnt_share_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  localparam int PCW = 16;
  localparam int BLAT_MIN = 1;
  localparam int BLAT_MAX = 8;
endpackage

// File: rtl/cnt_wrap.sv
// cnt_wrap: enabled, clearable counter that wraps to 0 after reaching period.
module cnt_wrap #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] period,
  output logic [W-1:0] cnt,
  output logic         wrap
);
  assign wrap = en && cnt == period;
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : en ? (wrap ? '0 : cnt + 1'b1) : cnt;
endmodule

// File: rtl/cnt_share_pipe_array.sv
// cnt_share_pipe_array: run-controlled wrap counter fanned out through BDIM pipelined groups.
// Optional CNT_SHARE_BITREV_EN publishes the count bit-reversed (van der Corput order).
module cnt_share_pipe_array
  import cnt_share_pkg::*;
#(
  parameter int CWID = 8,
  parameter int BDIM = 4,
  parameter int SDIM = 8,
  parameter int BLAT = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic            start,
  input  logic            stop,
  input  logic            clr,
  input  logic [CWID-1:0] period_max,
  input  logic [15:0]     len,
  output logic            busy,
  output logic            done,
  output logic [CWID-1:0] cnt_seq [BDIM*SDIM],
  output logic [BDIM-1:0] seq_vld,
  output logic [BDIM-1:0] seq_wrap
);
  state_t state, nxt;
  logic [CWID-1:0] cnt, period_q, s0_cnt;
  logic [PCW-1:0] pcnt, len_q;
  logic [3:0] dcnt;
  logic run, load, en, wrap, last;
  if (BLAT < BLAT_MIN || BLAT > BLAT_MAX) begin : g_bad_blat
    $error("BLAT out of range");
  end
  assign run  = state == RUN;
  assign load = state == IDLE && start;
  assign en   = run && enable;
  assign last = wrap && !clr && len_q != '0 && pcnt == len_q - 1'b1;
  cnt_wrap #(.W(CWID)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (clr || load),
    .en     (en),
    .period (period_q),
    .cnt    (cnt),
    .wrap   (wrap)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : nxt;
  always_comb begin
    nxt  = state;
    busy = run || state == DRAIN;
    done = state == DONE;
    nxt  = state == IDLE  ? (start ? RUN : IDLE) :
           state == RUN   ? ((stop || last) ? DRAIN : RUN) :
           state == DRAIN ? (dcnt == 4'(BLAT-1) ? DONE : DRAIN) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= '0;
      len_q    <= '0;
      pcnt     <= '0;
      dcnt     <= '0;
    end else begin
      if (load) begin
        period_q <= period_max;
        len_q    <= len;
      end
      pcnt <= (clr || load) ? '0 : wrap ? pcnt + 1'b1 : pcnt;
      dcnt <= state == DRAIN ? dcnt + 1'b1 : '0;
    end
  end
  always_comb begin
    s0_cnt = cnt;
`ifdef CNT_SHARE_BITREV_EN
    for (int b = 0; b < CWID; b++) s0_cnt[b] = cnt[CWID-1-b];
`endif
  end
  // Each group carries {count, valid, wrap} through its own BLAT-deep register chain.
  for (genvar g = 0; g < BDIM; g++) begin : grp
    logic [CWID+1:0] pipe [BLAT];
    always_ff @(posedge clk) begin
      pipe[0] <= rst ? '0 : {s0_cnt, en, wrap};
      for (int k = 1; k < BLAT; k++) pipe[k] <= rst ? '0 : pipe[k-1];
    end
    assign seq_vld[g]  = pipe[BLAT-1][1];
    assign seq_wrap[g] = pipe[BLAT-1][0];
    for (genvar j = 0; j < SDIM; j++) begin : fan
      assign cnt_seq[g*SDIM+j] = pipe[BLAT-1][CWID+1:2];
    end
  end
endmodule
